// File: rtl/pipeline_stage_reg.sv
// Parametrised inter-stage pipeline register with a valid/ready handshake,
// an optional skid entry, flush with bubble insertion and saturating stall/flush counters.
module pipeline_stage_reg #(
    parameter int CTRL_W    = 16,
    parameter int DATA_W    = 160,
    parameter int SKID_EN   = 1,
    parameter int ZERO_DATA = 0,
    parameter int CNT_W     = 16
) (
    input  logic              CLK,
    input  logic              CLR,
    input  logic              FLUSH,
    input  logic              valid_in,
    output logic              ready_out,
    input  logic [CTRL_W-1:0] ctrl_in,
    input  logic [DATA_W-1:0] data_in,
    output logic              valid_out,
    input  logic              ready_in,
    output logic [CTRL_W-1:0] ctrl_out,
    output logic [DATA_W-1:0] data_out,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_FULL  = 2'd1,
        ST_SKID  = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic              rdy_q, rdy_d;
    logic [CTRL_W-1:0] main_ctrl_q, main_ctrl_d;
    logic [CTRL_W-1:0] skid_ctrl_q, skid_ctrl_d;
    logic [DATA_W-1:0] main_data_q, main_data_d;
    logic [DATA_W-1:0] skid_data_q, skid_data_d;
    logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0]  flush_cnt_q, flush_cnt_d;
    logic              accept, issue;

    assign accept = valid_in & ready_out;
    assign issue  = valid_out & ready_in;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge CLK) begin
        if (CLR) begin
            state_q     <= ST_EMPTY;
            rdy_q       <= 1'b1;
            main_ctrl_q <= '0;
            skid_ctrl_q <= '0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            rdy_q       <= rdy_d;
            main_ctrl_q <= main_ctrl_d;
            skid_ctrl_q <= skid_ctrl_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    // NOTE: wide payload registers are not reset; the state says whether they hold anything.
    always_ff @(posedge CLK) begin
        if (CLR) begin
            if (ZERO_DATA != 0) main_data_q <= '0;
        end else begin
            main_data_q <= main_data_d;
            skid_data_q <= skid_data_d;
        end
    end

    // NOTE: every signal gets a default first so no path through this block infers a latch.
    always_comb begin
        state_d     = state_q;
        main_ctrl_d = main_ctrl_q;
        main_data_d = main_data_q;
        skid_ctrl_d = skid_ctrl_q;
        skid_data_d = skid_data_q;

        if (FLUSH) begin
            state_d     = ST_EMPTY;
            main_ctrl_d = '0;
            skid_ctrl_d = '0;
            if (ZERO_DATA != 0) begin
                main_data_d = '0;
                skid_data_d = '0;
            end
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (accept) begin
                        main_ctrl_d = ctrl_in;
                        main_data_d = data_in;
                        state_d     = ST_FULL;
                    end
                end
                ST_FULL: begin
                    if (accept && issue) begin
                        main_ctrl_d = ctrl_in;
                        main_data_d = data_in;
                    end else if (accept && SKID_EN != 0) begin
                        skid_ctrl_d = ctrl_in;
                        skid_data_d = data_in;
                        state_d     = ST_SKID;
                    end else if (issue) begin
                        state_d = ST_EMPTY;
                    end
                end
                ST_SKID: begin
                    // The older skid entry always moves up before anything newer is taken.
                    if (issue) begin
                        main_ctrl_d = skid_ctrl_q;
                        main_data_d = skid_data_q;
                        state_d     = ST_FULL;
                    end
                end
                default: state_d = ST_EMPTY;
            endcase
        end

        rdy_d = (state_d != ST_SKID);

        stall_cnt_d = stall_cnt_q;
        if (valid_out && !ready_in && stall_cnt_q != '1)
            stall_cnt_d = stall_cnt_q + CNT_W'(1);

        flush_cnt_d = flush_cnt_q;
        if (FLUSH && state_q != ST_EMPTY && flush_cnt_q != '1)
            flush_cnt_d = flush_cnt_q + CNT_W'(1);
    end

    always_comb begin
        valid_out = (state_q != ST_EMPTY);
        ready_out = (SKID_EN != 0) ? rdy_q : (ready_in | ~valid_out);
        ctrl_out  = main_ctrl_q & {CTRL_W{valid_out}};
        data_out  = main_data_q;
        stall_cnt = stall_cnt_q;
        flush_cnt = flush_cnt_q;
    end

endmodule
